mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-master bus controller that decodes CPU accesses onto
// peripheral, RAM and ROM ports and returns a one-cycle ack with an error flag.
// Optional feature macro MEM_BUS_TIMEOUT_EN: bounds the RAM write-done wait to
// TIMEOUT_CYC cycles and acks with err=1 when it expires. Without the macro the
// WAIT state holds until ram_write_done.
module mem_bus_ctrl #(
  parameter logic [15:0] RAM_BASE    = 16'h0200,
  parameter logic [15:0] RAM_TOP     = 16'h0400,
  parameter logic [15:0] ROM_BASE    = 16'hC000,
  parameter int          TIMEOUT_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_bw,
  output logic        cpu_ready,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [15:0] cpu_rdata,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_Din,
  output logic        ram_RW,
  output logic        BW,
  input  logic        ram_write_done,
  input  logic [15:0] ram_out,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_out,
  output logic [15:0] per_addr,
  output logic [15:0] per_din,
  output logic        per_we,
  output logic        per_bw,
  input  logic [15:0] per_dout
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_WAIT, S_ACK} state_t;
  typedef enum logic [1:0] {R_PER, R_RAM, R_ROM, R_UNM} region_t;

  state_t      state, state_n;
  logic [15:0] addr_q, wdata_q;
  logic        we_q, bw_q;
  logic [15:0] in_addr, src;
  region_t     in_reg, cur_reg;
  logic        accept, fault_in, tmo;

  function automatic region_t decode(input logic [15:0] a);
    if (a < 16'h0200)                   return R_PER;
    else if (a >= RAM_BASE && a < RAM_TOP) return R_RAM;
    else if (a >= ROM_BASE)             return R_ROM;
    else                                return R_UNM;
  endfunction

  // Word accesses are forced to even addresses; byte accesses pass through.
  assign in_addr  = cpu_bw ? cpu_addr : {cpu_addr[15:1], 1'b0};
  assign in_reg   = decode(in_addr);
  assign cur_reg  = decode(addr_q);
  assign accept   = cpu_req && (state == S_IDLE);
  // ROM is read-only; unmapped space faults for both directions.
  assign fault_in = (cpu_we && in_reg == R_ROM) || (in_reg == R_UNM);

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wait_cnt;

  // Count cycles spent in WAIT; cleared whenever we are elsewhere.
  always_ff @(posedge clk) begin
    if (!rst_n || state != S_WAIT) wait_cnt <= '0;
    else                           wait_cnt <= wait_cnt + 1'b1;
  end

  // Done wins over an expiry landing in the same cycle.
  assign tmo = (state == S_WAIT) && !ram_write_done && (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (cpu_req) state_n = fault_in ? S_ACK : (cpu_we ? S_WRITE : S_READ);
      S_READ:  state_n = S_ACK;
      S_WRITE: state_n = (cur_reg == R_RAM) ? S_WAIT : S_ACK;
      S_WAIT:  if (ram_write_done || tmo) state_n = S_ACK;
      S_ACK:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM-decoded outputs: ready in IDLE, one-cycle write strobes in WRITE.
  always_comb begin
    cpu_ready = (state == S_IDLE);
    ram_RW    = (state == S_WRITE) && we_q && (cur_reg == R_RAM);
    per_we    = (state == S_WRITE) && we_q && (cur_reg == R_PER);
  end

  // Read source selected from the captured address.
  always_comb begin
    case (cur_reg)
      R_RAM:   src = ram_out;
      R_ROM:   src = rom_out;
      R_PER:   src = per_dout;
      default: src = 16'h0000;
    endcase
  end

  // Request capture and completion registers (ack, err, read data).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      bw_q      <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      if (accept) begin
        addr_q    <= in_addr;
        wdata_q   <= cpu_wdata;
        we_q      <= cpu_we;
        bw_q      <= cpu_bw;
        cpu_rdata <= '0;
        cpu_err   <= fault_in;
        cpu_ack   <= fault_in;
      end
      if (state == S_READ) begin
        cpu_rdata <= bw_q ? {8'h00, src[7:0]} : src;
        cpu_err   <= 1'b0;
        cpu_ack   <= 1'b1;
      end
      if (state == S_WRITE && cur_reg == R_PER) begin
        cpu_err <= 1'b0;
        cpu_ack <= 1'b1;
      end
      if (state == S_WAIT && (ram_write_done || tmo)) begin
        cpu_err <= tmo;
        cpu_ack <= 1'b1;
      end
    end
  end

  assign ram_addr = addr_q - RAM_BASE;
  assign rom_addr = addr_q - ROM_BASE;
  assign per_addr = addr_q;
  assign ram_Din  = wdata_q;
  assign per_din  = wdata_q;
  assign BW       = bw_q;
  assign per_bw   = bw_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: RAM/ROM/peripheral accesses, alignment,
// faults, WAIT behaviour (with or without MEM_BUS_TIMEOUT_EN) and reset.
module tb_mem_bus_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cpu_req = 0, cpu_we = 0, cpu_bw = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0;
  logic cpu_ready, cpu_ack, cpu_err;
  logic [15:0] cpu_rdata, ram_addr, ram_Din, rom_addr, per_addr, per_din;
  logic ram_RW, BW, per_we, per_bw;
  logic ram_write_done = 0;
  logic [15:0] ram_out = 0, rom_out = 0, per_dout = 0;

  int n_checks = 0, n_fail = 0;
  int o_lat, o_rampulse, o_perpulse;
  logic o_err, o_bw;
  logic [15:0] o_rd, o_ramaddr, o_romaddr, o_din;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_bw(cpu_bw),
    .cpu_ready(cpu_ready), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .ram_addr(ram_addr), .ram_Din(ram_Din),
    .ram_RW(ram_RW), .BW(BW), .ram_write_done(ram_write_done),
    .ram_out(ram_out), .rom_addr(rom_addr), .rom_out(rom_out),
    .per_addr(per_addr), .per_din(per_din), .per_we(per_we),
    .per_bw(per_bw), .per_dout(per_dout)
  );

  // Issue one request from IDLE and record what the bus did until ack.
  // o_lat = cycles from acceptance edge to ack (-1 if no ack in 40 cycles).
  task automatic access(input logic [15:0] a, input logic [15:0] wd,
                        input logic we, input logic bw, input int done_after);
    o_lat = -1; o_rampulse = 0; o_perpulse = 0; o_err = 1'bx; o_rd = 'x;
    o_bw = 1'bx; o_din = 'x; o_ramaddr = 'x; o_romaddr = 'x;
    cpu_addr = a; cpu_wdata = wd; cpu_we = we; cpu_bw = bw; cpu_req = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ram_RW) begin o_rampulse++; o_bw = BW; o_din = ram_Din; end
      if (per_we) begin o_perpulse++; o_bw = per_bw; o_din = per_din; end
      if (i == 1) begin o_ramaddr = ram_addr; o_romaddr = rom_addr; end
      if (cpu_ack) begin o_lat = i; o_err = cpu_err; o_rd = cpu_rdata; break; end
      ram_write_done = (i >= done_after);
    end
    cpu_req = 1'b0; ram_write_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", cpu_ready); end
    n_checks++; if ({cpu_ack, cpu_err, ram_RW, per_we} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b expected 0000", {cpu_ack, cpu_err, ram_RW, per_we}); end
    n_checks++; if (cpu_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0000", cpu_rdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ram_word;
    access(16'h0300, 16'hBEEF, 1'b1, 1'b0, 2);
    n_checks++; if (o_ramaddr !== 16'h0100) begin n_fail++; $display("FAIL ramw_addr: got %h expected 0100", o_ramaddr); end
    n_checks++; if (o_rampulse !== 1 || o_perpulse !== 0) begin n_fail++; $display("FAIL ramw_pulses: got ram=%0d per=%0d expected 1/0", o_rampulse, o_perpulse); end
    n_checks++; if (o_din !== 16'hBEEF || o_bw !== 1'b0) begin n_fail++; $display("FAIL ramw_data: got %h bw=%b expected BEEF bw=0", o_din, o_bw); end
    n_checks++; if (o_lat !== 3 || o_err !== 1'b0) begin n_fail++; $display("FAIL ramw_ack: got lat=%0d err=%b expected 3/0", o_lat, o_err); end
    ram_out = 16'hBEEF;
    access(16'h0300, 16'h0000, 1'b0, 1'b0, 2);
    n_checks++; if (o_lat !== 2 || o_err !== 1'b0) begin n_fail++; $display("FAIL ramr_ack: got lat=%0d err=%b expected 2/0", o_lat, o_err); end
    n_checks++; if (o_rd !== 16'hBEEF) begin n_fail++; $display("FAIL ramr_data: got %h expected BEEF", o_rd); end
    n_checks++; if (o_rampulse !== 0) begin n_fail++; $display("FAIL ramr_nostrobe: got %0d expected 0", o_rampulse); end
  endtask

  task automatic test_ram_byte;
    access(16'h0201, 16'h12AB, 1'b1, 1'b1, 2);
    n_checks++; if (o_ramaddr !== 16'h0001 || o_bw !== 1'b1) begin n_fail++; $display("FAIL ramb_wr: got addr=%h bw=%b expected 0001/1", o_ramaddr, o_bw); end
    ram_out = 16'h12AB;
    access(16'h0201, 16'h0000, 1'b0, 1'b1, 2);
    n_checks++; if (o_ramaddr !== 16'h0001) begin n_fail++; $display("FAIL ramb_raddr: got %h expected 0001", o_ramaddr); end
    n_checks++; if (o_rd !== 16'h00AB || o_lat !== 2) begin n_fail++; $display("FAIL ramb_rd: got %h lat=%0d expected 00AB/2", o_rd, o_lat); end
  endtask

  task automatic test_align;
    ram_out = 16'h5A5A;
    access(16'h0303, 16'h0000, 1'b0, 1'b0, 2);
    n_checks++; if (o_ramaddr !== 16'h0102) begin n_fail++; $display("FAIL align_addr: got %h expected 0102", o_ramaddr); end
    n_checks++; if (o_rd !== 16'h5A5A) begin n_fail++; $display("FAIL align_rd: got %h expected 5A5A", o_rd); end
  endtask

  task automatic test_faults;
    access(16'hC000, 16'h1111, 1'b1, 1'b0, 2);
    n_checks++; if (o_lat !== 1 || o_err !== 1'b1) begin n_fail++; $display("FAIL romw_ack: got lat=%0d err=%b expected 1/1", o_lat, o_err); end
    n_checks++; if (o_rampulse !== 0 || o_perpulse !== 0 || o_rd !== 16'h0000) begin n_fail++; $display("FAIL romw_side: got ram=%0d per=%0d rd=%h expected 0/0/0000", o_rampulse, o_perpulse, o_rd); end
    ram_out = 16'hFFFF;
    access(16'h8000, 16'h0000, 1'b0, 1'b0, 2);
    n_checks++; if (o_lat !== 1 || o_err !== 1'b1 || o_rd !== 16'h0000) begin n_fail++; $display("FAIL unm_rd: got lat=%0d err=%b rd=%h expected 1/1/0000", o_lat, o_err, o_rd); end
  endtask

  task automatic test_rom_periph;
    rom_out = 16'hCAFE;
    access(16'hC010, 16'h0000, 1'b0, 1'b0, 2);
    n_checks++; if (o_rd !== 16'hCAFE || o_romaddr !== 16'h0010 || o_err !== 1'b0) begin n_fail++; $display("FAIL rom_rd: got rd=%h addr=%h err=%b expected CAFE/0010/0", o_rd, o_romaddr, o_err); end
    access(16'h0010, 16'h7777, 1'b1, 1'b1, 2);
    n_checks++; if (o_lat !== 2 || o_perpulse !== 1 || o_rampulse !== 0) begin n_fail++; $display("FAIL per_wr: got lat=%0d per=%0d ram=%0d expected 2/1/0", o_lat, o_perpulse, o_rampulse); end
    n_checks++; if (o_din !== 16'h7777 || o_bw !== 1'b1 || o_err !== 1'b0) begin n_fail++; $display("FAIL per_wdata: got %h bw=%b err=%b expected 7777/1/0", o_din, o_bw, o_err); end
    per_dout = 16'h9988;
    access(16'h01FF, 16'h0000, 1'b0, 1'b1, 2);
    n_checks++; if (o_rd !== 16'h0088 || o_lat !== 2) begin n_fail++; $display("FAIL per_rd: got %h lat=%0d expected 0088/2", o_rd, o_lat); end
  endtask

  task automatic test_wait;
    access(16'h0250, 16'h4242, 1'b1, 1'b0, 12);
`ifdef MEM_BUS_TIMEOUT_EN
    n_checks++; if (o_lat !== 6 || o_err !== 1'b1) begin n_fail++; $display("FAIL wait_tmo: got lat=%0d err=%b expected 6/1", o_lat, o_err); end
`else
    n_checks++; if (o_lat !== 13 || o_err !== 1'b0) begin n_fail++; $display("FAIL wait_hold: got lat=%0d err=%b expected 13/0", o_lat, o_err); end
`endif
  endtask

  task automatic test_back_to_back;
    ram_out = 16'h2468;
    access(16'h0300, 16'h0000, 1'b0, 1'b0, 2);
    @(negedge clk);
    n_checks++; if (cpu_ack !== 1'b0 || cpu_ready !== 1'b1) begin n_fail++; $display("FAIL ack_once: got ack=%b ready=%b expected 0/1", cpu_ack, cpu_ready); end
    @(posedge clk); #1;
    ram_out = 16'h1357;
    access(16'h0302, 16'h0000, 1'b0, 1'b0, 2);
    n_checks++; if (o_rd !== 16'h1357 || o_lat !== 2) begin n_fail++; $display("FAIL b2b_rd: got %h lat=%0d expected 1357/2", o_rd, o_lat); end
  endtask

  task automatic test_reset_in_wait;
    cpu_addr = 16'h0200; cpu_wdata = 16'h5555; cpu_we = 1'b1; cpu_bw = 1'b0; cpu_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (ram_RW !== 1'b0 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL wait_state: got rw=%b ready=%b expected 0/0", ram_RW, cpu_ready); end
    rst_n = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b1 || cpu_ack !== 1'b0 || ram_RW !== 1'b0) begin n_fail++; $display("FAIL rst_wait: got ready=%b ack=%b rw=%b expected 1/0/0", cpu_ready, cpu_ack, ram_RW); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    ram_out = 16'hA5C3;
    access(16'h0200, 16'h0000, 1'b0, 1'b0, 2);
    n_checks++; if (o_rd !== 16'hA5C3 || o_lat !== 2 || o_err !== 1'b0) begin n_fail++; $display("FAIL post_rst_rd: got %h lat=%0d err=%b expected A5C3/2/0", o_rd, o_lat, o_err); end
  endtask

  initial begin
    test_reset();
    test_ram_word();
    test_ram_byte();
    test_align();
    test_faults();
    test_rom_periph();
    test_wait();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
